// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of the datapath ALU between two requesters
module alu_arbiter #(
    parameter int DATA_W      = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [2:0]        aluop0,
    input  logic [2:0]        aluop1,
    input  logic [5:0]        funct0,
    input  logic [5:0]        funct1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rsp_valid0,
    output logic              rsp_valid1,
    input  logic              rsp_ready0,
    input  logic              rsp_ready1,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic [2:0]        alu_aluop,
    output logic [5:0]        alu_funct,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t     state, state_nx;
    logic       prio;
    logic       owner;
    logic [3:0] cnt;
    logic       grant_any;
    logic       grant_sel;
    logic       owner_ready;

    assign owner_ready = owner ? rsp_ready1 : rsp_ready0;

    // Grants are suppressed while reset is held so every output reads 0 during reset.
    always_comb begin
        state_nx  = state;
        grant_any = 1'b0;
        grant_sel = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rst && (req0 || req1)) begin
                    grant_any = 1'b1;
                    grant_sel = (req0 && req1) ? prio : req1;
                    state_nx  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt == 4'd0) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                if (owner_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign gnt0       = grant_any && !grant_sel;
    assign gnt1       = grant_any && grant_sel;
    assign rsp_valid0 = (state == S_RESP) && !owner;
    assign rsp_valid1 = (state == S_RESP) && owner;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            prio       <= 1'b0;
            owner      <= 1'b0;
            cnt        <= 4'd0;
            alu_aluop  <= 3'd0;
            alu_funct  <= 6'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        owner     <= grant_sel;
                        cnt       <= CNT_INIT;
                        alu_aluop <= grant_sel ? aluop1 : aluop0;
                        alu_funct <= grant_sel ? funct1 : funct0;
                        alu_a     <= grant_sel ? a1 : a0;
                        alu_b     <= grant_sel ? b1 : b0;
                    end
                end
                S_EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                    end
                end
                S_RESP: begin
                    // Pointer moves only at completion: the last winner yields the next contest.
                    if (owner_ready) begin
                        prio <= ~owner;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed checks of alu_arbiter against a transaction model
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int EA = 1;
    localparam int EB = 3;

    localparam logic [2:0] ALUop_ADD   = 3'd0;
    localparam logic [2:0] ALUop_SUB   = 3'd1;
    localparam logic [2:0] ALUop_RTYPE = 3'd2;
    localparam logic [2:0] ALUop_LESS  = 3'd3;
    localparam logic [2:0] ALUop_OR    = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          req0_a = 0, req1_a = 0, rsp_ready0_a = 0, rsp_ready1_a = 0;
    logic [2:0]    aluop0_a = 0, aluop1_a = 0;
    logic [5:0]    funct0_a = 0, funct1_a = 0;
    logic [DW-1:0] a0_a = 0, b0_a = 0, a1_a = 0, b1_a = 0;
    logic          gnt0_a, gnt1_a, rsp_valid0_a, rsp_valid1_a, rsp_zero_a, alu_zero_a, busy_a;
    logic [DW-1:0] rsp_result_a, alu_a_a, alu_b_a, alu_result_a;
    logic [2:0]    alu_aluop_a;
    logic [5:0]    alu_funct_a;

    logic          req0_b = 0, req1_b = 0, rsp_ready0_b = 0, rsp_ready1_b = 0;
    logic [2:0]    aluop0_b = 0, aluop1_b = 0;
    logic [5:0]    funct0_b = 0, funct1_b = 0;
    logic [DW-1:0] a0_b = 0, b0_b = 0, a1_b = 0, b1_b = 0;
    logic          gnt0_b, gnt1_b, rsp_valid0_b, rsp_valid1_b, rsp_zero_b, alu_zero_b, busy_b;
    logic [DW-1:0] rsp_result_b, alu_a_b, alu_b_b, alu_result_b;
    logic [2:0]    alu_aluop_b;
    logic [5:0]    alu_funct_b;

    int   chk_cnt = 0;
    int   pass_cnt = 0;
    logic m_prio = 1'b0;

    logic [2:0] op_tab [5] = '{ALUop_ADD, ALUop_SUB, ALUop_RTYPE, ALUop_LESS, ALUop_OR};
    logic [5:0] fn_tab [3] = '{6'h03, 6'h20, 6'h25};

    always #5 clk = ~clk;

    // Stub ALU: {zero, result} for an operation.
    function automatic logic [DW:0] ref_alu(input logic [2:0] op, input logic [5:0] fn,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (op)
            ALUop_ADD:   r = a + b;
            ALUop_SUB:   r = a - b;
            ALUop_LESS:  r = (a < b) ? 1 : 0;
            ALUop_OR:    r = a | b;
            ALUop_RTYPE: r = (fn == 6'h03) ? a - b : (fn == 6'h25) ? (a | b) : a + b;
            default:     r = '0;
        endcase
        return {r == '0, r};
    endfunction

    assign {alu_zero_a, alu_result_a} = ref_alu(alu_aluop_a, alu_funct_a, alu_a_a, alu_b_a);
    assign {alu_zero_b, alu_result_b} = ref_alu(alu_aluop_b, alu_funct_b, alu_a_b, alu_b_b);

    alu_arbiter #(.DATA_W(DW), .EXEC_CYCLES(EA)) dut_a (
        .clk(clk), .rst(rst), .req0(req0_a), .req1(req1_a),
        .aluop0(aluop0_a), .aluop1(aluop1_a), .funct0(funct0_a), .funct1(funct1_a),
        .a0(a0_a), .b0(b0_a), .a1(a1_a), .b1(b1_a), .gnt0(gnt0_a), .gnt1(gnt1_a),
        .rsp_valid0(rsp_valid0_a), .rsp_valid1(rsp_valid1_a),
        .rsp_ready0(rsp_ready0_a), .rsp_ready1(rsp_ready1_a),
        .rsp_result(rsp_result_a), .rsp_zero(rsp_zero_a),
        .alu_aluop(alu_aluop_a), .alu_funct(alu_funct_a), .alu_a(alu_a_a), .alu_b(alu_b_a),
        .alu_result(alu_result_a), .alu_zero(alu_zero_a), .busy(busy_a)
    );

    alu_arbiter #(.DATA_W(DW), .EXEC_CYCLES(EB)) dut_b (
        .clk(clk), .rst(rst), .req0(req0_b), .req1(req1_b),
        .aluop0(aluop0_b), .aluop1(aluop1_b), .funct0(funct0_b), .funct1(funct1_b),
        .a0(a0_b), .b0(b0_b), .a1(a1_b), .b1(b1_b), .gnt0(gnt0_b), .gnt1(gnt1_b),
        .rsp_valid0(rsp_valid0_b), .rsp_valid1(rsp_valid1_b),
        .rsp_ready0(rsp_ready0_b), .rsp_ready1(rsp_ready1_b),
        .rsp_result(rsp_result_b), .rsp_zero(rsp_zero_b),
        .alu_aluop(alu_aluop_b), .alu_funct(alu_funct_b), .alu_a(alu_a_b), .alu_b(alu_b_b),
        .alu_result(alu_result_b), .alu_zero(alu_zero_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic raise(input int p, input logic [2:0] op, input logic [5:0] fn,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (p == 0) begin
            req0_a = 1; aluop0_a = op; funct0_a = fn; a0_a = a; b0_a = b;
        end else begin
            req1_a = 1; aluop1_a = op; funct1_a = fn; a1_a = a; b1_a = b;
        end
    endtask

    task automatic raise_rand(input int p);
        logic [DW-1:0] a;
        a = $urandom;
        raise(p, op_tab[$urandom_range(0, 4)], fn_tab[$urandom_range(0, 2)], a,
              ($urandom_range(0, 3) == 0) ? a : DW'($urandom));
    endtask

    // One full transaction on dut_a, entered from IDLE #1 after an edge with requests applied.
    task automatic do_txn(input int delay);
        logic          w;
        logic [DW:0]   e;
        logic [DW-1:0] ea, eb;
        #1;
        w  = (req0_a && req1_a) ? m_prio : !req0_a;
        e  = w ? ref_alu(aluop1_a, funct1_a, a1_a, b1_a) : ref_alu(aluop0_a, funct0_a, a0_a, b0_a);
        ea = w ? a1_a : a0_a;
        eb = w ? b1_a : b0_a;
        chk("idle_busy", busy_a, 0);
        chk("gnt0", gnt0_a, !w);
        chk("gnt1", gnt1_a, w);
        @(posedge clk); #1;
        if (w) req1_a = 0; else req0_a = 0;
        for (int k = 0; k < EA; k++) begin
            #1;
            chk("exec_busy", busy_a, 1);
            chk("exec_gnt", {gnt0_a, gnt1_a}, 0);
            chk("exec_valid", {rsp_valid0_a, rsp_valid1_a}, 0);
            chk("exec_alu_a", alu_a_a, ea);
            chk("exec_alu_b", alu_b_a, eb);
            @(posedge clk); #1;
        end
        for (int d = 0; d <= delay; d++) begin
            #1;
            chk("rsp_valid", {rsp_valid1_a, rsp_valid0_a}, w ? 2'b10 : 2'b01);
            chk("rsp_result", rsp_result_a, e[DW-1:0]);
            chk("rsp_zero", rsp_zero_a, e[DW]);
            chk("resp_gnt", {gnt0_a, gnt1_a}, 0);
            if (w) begin
                rsp_ready1_a = (d == delay); rsp_ready0_a = 1'($urandom_range(0, 1));
            end else begin
                rsp_ready0_a = (d == delay); rsp_ready1_a = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        rsp_ready0_a = 0;
        rsp_ready1_a = 0;
        m_prio = !w;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", {rsp_valid0_a, rsp_valid1_a}, 0);
        chk("rst_alu_a", alu_a_a, 0);
        chk("rst_result", rsp_result_a, 0);
        chk("rst_funct_b", alu_funct_b, 0);
        rst = 0;
        @(posedge clk); #1;

        raise(0, ALUop_ADD, 6'd0, 5, 7);
        do_txn(0);
        #1;
        chk("single_busy_c3", busy_a, 0);
        chk("single_result", rsp_result_a, 12);
        chk("single_zero", rsp_zero_a, 0);
        @(posedge clk); #1;

        raise(1, ALUop_RTYPE, 6'b000011, 9, 9);
        do_txn(0);
        chk("rtype_funct", alu_funct_a, 6'b000011);
        chk("rtype_zero", rsp_zero_a, 1);
        chk("rtype_result", rsp_result_a, 0);

        raise(0, ALUop_OR, 6'd0, 32'hf0, 32'h0f);
        raise(1, ALUop_ADD, 6'd0, 1, 2);
        do_txn(5);
        do_txn(0);

        for (int i = 0; i < 4; i++) begin
            if (!req0_a) raise_rand(0);
            if (!req1_a) raise_rand(1);
            do_txn(0);
        end

        for (int i = 0; i < 40; i++) begin
            if (!req0_a && $urandom_range(0, 1) == 1) raise_rand(0);
            if (!req1_a && $urandom_range(0, 1) == 1) raise_rand(1);
            if (!req0_a && !req1_a) raise_rand(int'($urandom_range(0, 1)));
            do_txn(int'($urandom_range(0, 3)));
        end
        if (req0_a || req1_a) do_txn(0);

        req0_b = 1; aluop0_b = ALUop_ADD; a0_b = 100; b0_b = 23;
        #1;
        chk("b_gnt0", gnt0_b, 1);
        @(posedge clk); #1;
        req0_b = 0;
        for (int c = 1; c <= EB; c++) begin
            #1;
            chk("b_hold_a", alu_a_b, 100);
            chk("b_hold_b", alu_b_b, 23);
            chk("b_no_valid", rsp_valid0_b, 0);
            @(posedge clk); #1;
        end
        #1;
        chk("b_valid_c4", rsp_valid0_b, 1);
        chk("b_result", rsp_result_b, 123);
        rsp_ready0_b = 1;
        @(posedge clk); #1;
        rsp_ready0_b = 0;
        #1;
        chk("b_idle", busy_b, 0);

        req1_b = 1; aluop1_b = ALUop_SUB; a1_b = 50; b1_b = 8;
        #1;
        chk("b_gnt1", gnt1_b, 1);
        @(posedge clk); #1;
        req1_b = 0;
        rsp_ready1_b = 1;
        #2;
        rst = 1;
        #1;
        chk("mid_rst_busy", busy_b, 0);
        chk("mid_rst_alu_a", alu_a_b, 0);
        chk("mid_rst_alu_b", alu_b_b, 0);
        chk("mid_rst_aluop", alu_aluop_b, 0);
        chk("mid_rst_result", rsp_result_b, 0);
        chk("mid_rst_zero", rsp_zero_b, 0);
        chk("mid_rst_valid", {rsp_valid0_b, rsp_valid1_b}, 0);
        chk("mid_rst_a_alu", alu_a_a, 0);
        @(posedge clk); #1;
        rst = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("post_rst_valid", {rsp_valid0_b, rsp_valid1_b}, 0);
            chk("post_rst_busy", busy_b, 0);
            @(posedge clk); #1;
        end
        req0_b = 1; req1_b = 1;
        #1;
        chk("post_rst_gnt0", gnt0_b, 1);
        chk("post_rst_gnt1", gnt1_b, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single datapath ALU (fed through `alu_control`) between two requesters: port 0, the main execute stage, and port 1, the branch/address unit. The block arbitrates round-robin, latches the winner's ALUop, function code and operands, and holds them on the ALU for a configurable settle time. It then captures the result and returns it to the winner over a valid/ready response handshake. One operation is in flight at a time.

## Interface
- `DATA_W`, 32: operand/result width.
- `EXEC_CYCLES`, 1: cycles the latched operands are held on the ALU before capture; legal range 1..15.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0`, `req1` in 1: request; must stay high with stable payload until the matching `gnt` is seen.
- `aluop0`, `aluop1` in 3: ALUop code (`ALUop_RTYPE`, `ALUop_ADD`, `ALUop_SUB`, `ALUop_LESS`, `ALUop_OR` from mips_defines.vh).
- `funct0`, `funct1` in 6: function code, used when ALUop is `ALUop_RTYPE`.
- `a0`, `b0`, `a1`, `b1` in DATA_W: operands.
- `gnt0`, `gnt1` out 1: one-cycle accept pulse; the payload is latched on this edge.
- `rsp_valid0`, `rsp_valid1` out 1: result available for that requester.
- `rsp_ready0`, `rsp_ready1` in 1: requester consumes the result.
- `rsp_result` out DATA_W: shared result bus, valid only with a `rsp_valid*`.
- `rsp_zero` out 1: captured ALU zero flag.
- `alu_aluop` out 3, `alu_funct` out 6: drive `alu_control`.
- `alu_a`, `alu_b` out DATA_W: drive the ALU operands.
- `alu_result` in DATA_W, `alu_zero` in 1: combinational ALU outputs.
- `busy` out 1: high in any state except IDLE.

## Operation
- State machine: IDLE, EXEC, RESP.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If exactly one `req` is high, grant it.
  - If both are high, grant the requester selected by priority pointer `prio`: 0 selects port 0, 1 selects port 1.
  - On grant, assert `gnt<n>` combinationally in that cycle, and at the clock edge:
    - latch aluop, funct, a and b into the `alu_*` registers;
    - record `owner = n`;
    - load counter `cnt = EXEC_CYCLES-1`;
    - go to EXEC.
- **EXEC**
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0`:
    - capture `alu_result` into `rsp_result` and `alu_zero` into `rsp_zero`;
    - go to RESP.
- **RESP**
  - Assert `rsp_valid<owner>`.
  - On `rsp_ready<owner>` high: go to IDLE and set `prio = ~owner`.
  - `rsp_ready` of the non-owner is ignored.
- Pointer rule: `prio` toggles only at completion, so the winner of a contested grant loses the next contested grant.
- `alu_*` registers hold their last value outside grants. No new grant is issued until the response completes.
- Requests arriving while busy wait. `gnt` is never asserted outside IDLE.
- At most one of `gnt0`/`gnt1` is high. At most one `rsp_valid*` is high.
- Reset (async, any state, including mid-EXEC or mid-RESP):
  - state goes to IDLE; `prio = 0`; `owner = 0`; `cnt = 0`;
  - `alu_aluop = 0`, `alu_funct = 0`, `alu_a = 0`, `alu_b = 0`;
  - `rsp_result = 0`, `rsp_zero = 0`;
  - `gnt*`, `rsp_valid*` and `busy` go to 0;
  - the in-flight operation is dropped and no response is produced.

## Timing
- Grant in cycle T (IDLE). The ALU sees the latched operands from T+1.
- Result captured at the end of cycle T+EXEC_CYCLES. `rsp_valid` high from T+EXEC_CYCLES+1.
- Minimum occupancy, with ready already high: EXEC_CYCLES+2 cycles. The next grant can occur in cycle T+EXEC_CYCLES+2.
- `rsp_valid` stays high until the ready handshake, with `rsp_result` stable. Completion happens on the edge where valid and ready are both high.
- The ALU and `alu_control` paths are combinational. EXEC_CYCLES covers their settle time; the block performs no arithmetic on data.

## Test plan
- **Single request, port 0.** Reset, then `req0` with aluop=`ALUop_ADD`, a=5, b=7, and a stub ALU returning 12.
  - `gnt0` in cycle 0; `rsp_valid0` in cycle 2 with `rsp_result=12`, `rsp_zero=0`.
  - With `rsp_ready0=1`: `busy` low in cycle 3.
- **Contention.** `req0` and `req1` held high continuously, ready tied high.
  - Grants in order port 0, port 1, port 0, port 1.
  - Each response goes to the correct port with the correct operand-derived result.
  - `gnt0` and `gnt1` never high together.
- **R-type pass-through.** `req1` with aluop=`ALUop_RTYPE`, funct=6'b000011, a=9, b=9.
  - `alu_funct=6'b000011` latched.
  - `rsp_zero=1`, `rsp_result=0` (SUB).
- **Backpressure.** `rsp_ready0` held low for 5 cycles.
  - `rsp_valid0` and `rsp_result` stay stable for 5 cycles.
  - A concurrent `req1` receives no `gnt1` until the cycle after the handshake.
- **EXEC_CYCLES=3.** Grant in cycle 0.
  - `rsp_valid` first high in cycle 4.
  - `alu_a`/`alu_b` constant through cycles 1–3.
- **Reset mid-EXEC.** Assert `rst` asynchronously in cycle 1 with EXEC_CYCLES=3.
  - All outputs 0 immediately.
  - No `rsp_valid` afterwards.
  - After release, a contested request grants port 0 first.
